ov7670_bringup_ctrl: RTL and testbench

- Top-level bring-up sequencer for the OV7670 camera.
- Drives the camera PWDN and RESET pins with timed waits, then starts the SCCB register-load engine and waits for its done flag, with a timeout.
- After config, discards a programmable number of frames, then asserts capture_en to the pixel capture path.
- Sits between the top level / user button and the SCCB controller and capture logic.

---
 rtl/cam_pkg.sv | 40 ++++
 rtl/sync_edge_det.sv | 22 ++
 rtl/ov7670_bringup_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ov7670_bringup_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default timing for the OV7670 bring-up sequencer.
package cam_pkg;

    typedef enum logic [3:0] {
        S_OFF    = 4'd0,
        S_PWDN   = 4'd1,
        S_RST    = 4'd2,
        S_SETTLE = 4'd3,
        S_CFG    = 4'd4,
        S_SKIP   = 4'd5,
        S_RUN    = 4'd6,
        S_ERR    = 4'd7,
        S_RETRY  = 4'd8
    } bringup_state_t;

    // Registered output bundle; field order matches the 7-bit literals used in the top.
    typedef struct packed {
        logic sccb_start;
        logic sccb_reset;
        logic cam_pwdn;
        logic cam_resetn;
        logic capture_en;
        logic busy;
        logic error;
    } bringup_out_t;

    localparam bringup_out_t OUT_RESET = 7'b0_1_1_0_0_0_0;

    localparam int unsigned DEF_PWDN_CYCLES        = 2_400_000;
    localparam int unsigned DEF_RST_LOW_CYCLES     = 240_000;
    localparam int unsigned DEF_RST_SETTLE_CYCLES  = 2_400_000;
    localparam int unsigned DEF_CFG_TIMEOUT_CYCLES = 24_000_000;
    localparam int unsigned DEF_SKIP_FRAMES        = 2;
    localparam int unsigned DEF_MAX_RETRY          = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0] sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[1:0], d_i};
        end
    end

    assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/ov7670_bringup_ctrl.sv
// OV7670 bring-up: power-down/reset timing, SCCB config handshake with timeout, frame skip.
// Define BRINGUP_RETRY_EN to retry a timed-out configuration up to MAX_RETRY times.
module ov7670_bringup_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned PWDN_CYCLES        = DEF_PWDN_CYCLES,
    parameter int unsigned RST_LOW_CYCLES     = DEF_RST_LOW_CYCLES,
    parameter int unsigned RST_SETTLE_CYCLES  = DEF_RST_SETTLE_CYCLES,
    parameter int unsigned CFG_TIMEOUT_CYCLES = DEF_CFG_TIMEOUT_CYCLES,
    parameter int unsigned SKIP_FRAMES        = DEF_SKIP_FRAMES
`ifdef BRINGUP_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY          = DEF_MAX_RETRY
`endif
) (
    input  logic       xclk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       shutdown,
    input  logic       sccb_done,
    input  logic       cam_vsync,
    output logic       sccb_start,
    output logic       sccb_reset,
    output logic       cam_pwdn,
    output logic       cam_resetn,
    output logic       capture_en,
    output logic       busy,
    output logic       error,
    output logic [3:0] state_dbg
);

    localparam int unsigned MAX_CYC = max_u(max_u(PWDN_CYCLES, RST_LOW_CYCLES),
                                            max_u(RST_SETTLE_CYCLES, CFG_TIMEOUT_CYCLES));
    localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
    localparam int unsigned FR_W    = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

    bringup_state_t   state_q, state_d;
    bringup_state_t   timeout_st;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FR_W-1:0]  frames_q, frames_d;
    bringup_out_t     out_q, out_d;
    logic             vsync_rise;
    logic             cnt_zero;

    sync_edge_det u_vsync_det (
        .clk_i  (xclk),
        .rst_ni (reset_n),
        .d_i    (cam_vsync),
        .rise_o (vsync_rise)
    );

    assign cnt_zero = (cnt_q == '0);

`ifdef BRINGUP_RETRY_EN
    localparam int unsigned RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RT_W-1:0] retry_q, retry_d;

    assign timeout_st = (retry_q < RT_W'(MAX_RETRY)) ? S_RETRY : S_ERR;

    always_comb begin
        retry_d = retry_q;
        if (state_d == S_OFF) begin
            retry_d = '0;
        end else if (state_d == S_RETRY && state_q != S_RETRY) begin
            retry_d = retry_q + 1'b1;
        end
    end

    always_ff @(posedge xclk or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    assign timeout_st = S_ERR;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_zero ? cnt_q : cnt_q - 1'b1;
        frames_d = frames_q;
        case (state_q)
            S_OFF:    if (start) state_d = S_PWDN;
            S_PWDN:   if (cnt_zero) state_d = S_RST;
            S_RST:    if (cnt_zero) state_d = S_SETTLE;
            S_SETTLE: if (cnt_zero) state_d = S_CFG;
            S_CFG: begin
                if (sccb_done) begin
                    state_d = S_SKIP;
                end else if (cnt_zero) begin
                    state_d = timeout_st;
                end
            end
            S_SKIP: begin
                // Each frame edge restarts the per-frame timeout window.
                if (frames_q == '0) begin
                    state_d = S_RUN;
                end else if (vsync_rise) begin
                    if (frames_q == FR_W'(1)) begin
                        state_d = S_RUN;
                    end else begin
                        frames_d = frames_q - 1'b1;
                        cnt_d    = CNT_W'(CFG_TIMEOUT_CYCLES - 1);
                    end
                end else if (cnt_zero) begin
                    state_d = S_ERR;
                end
            end
            S_RUN:    state_d = S_RUN;
            S_ERR:    if (start) state_d = S_PWDN;
            S_RETRY:  if (cnt_zero) state_d = S_SETTLE;
            default:  state_d = S_OFF;
        endcase

        if (shutdown) begin
            state_d = S_OFF;
        end

        if (state_d != state_q) begin
            case (state_d)
                S_PWDN:          cnt_d = CNT_W'(PWDN_CYCLES - 1);
                S_RST, S_RETRY:  cnt_d = CNT_W'(RST_LOW_CYCLES - 1);
                S_SETTLE:        cnt_d = CNT_W'(RST_SETTLE_CYCLES - 1);
                S_CFG, S_SKIP:   cnt_d = CNT_W'(CFG_TIMEOUT_CYCLES - 1);
                default:         cnt_d = '0;
            endcase
            frames_d = FR_W'(SKIP_FRAMES);
        end
    end

    // Outputs follow the state being entered; S_ERR leaves the camera pins where they were.
    always_comb begin
        out_d = out_q;
        case (state_d)
            S_OFF:    out_d = OUT_RESET;
            //                  start rst pwdn resetn cap busy err
            S_PWDN:   out_d = 7'b0_1_1_0_0_1_0;
            S_RST:    out_d = 7'b0_1_0_0_0_1_0;
            S_SETTLE: out_d = 7'b0_0_0_1_0_1_0;
            S_CFG:    out_d = 7'b1_0_0_1_0_1_0;
            S_SKIP:   out_d = 7'b0_0_0_1_0_1_0;
            S_RUN:    out_d = 7'b0_0_0_1_1_0_0;
            S_RETRY:  out_d = 7'b0_1_0_0_0_1_0;
            S_ERR: begin
                out_d.sccb_start = 1'b0;
                out_d.capture_en = 1'b0;
                out_d.busy       = 1'b0;
                out_d.error      = 1'b1;
            end
            default:  out_d = OUT_RESET;
        endcase
    end

    always_ff @(posedge xclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            frames_q <= '0;
            out_q    <= OUT_RESET;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
            out_q    <= out_d;
        end
    end

    assign sccb_start = out_q.sccb_start;
    assign sccb_reset = out_q.sccb_reset;
    assign cam_pwdn   = out_q.cam_pwdn;
    assign cam_resetn = out_q.cam_resetn;
    assign capture_en = out_q.capture_en;
    assign busy       = out_q.busy;
    assign error      = out_q.error;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ov7670_bringup_ctrl.sv
// Bench for ov7670_bringup_ctrl: scoreboard of expected state changes with outputs and cycle stamps.
`timescale 1ns/1ps
module tb_ov7670_bringup_ctrl;

    localparam int PW = 10;
    localparam int RL = 5;
    localparam int ST = 8;
    localparam int TO = 100;
    localparam int SK = 2;
    localparam int W  = 43;
    localparam logic [6:0] RST_OUTS = 7'b0110000;

    logic       xclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       shutdown = 1'b0;
    logic       sccb_done = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       sccb_start, sccb_reset, cam_pwdn, cam_resetn, capture_en, busy, error;
    logic [3:0] state_dbg;
    logic [6:0] outs;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [3:0] last_state = 4'd0;
    logic [6:0] model_o = RST_OUTS;
    logic [W-1:0] exp_q[$];

    assign outs = {sccb_start, sccb_reset, cam_pwdn, cam_resetn, capture_en, busy, error};

    ov7670_bringup_ctrl #(
        .PWDN_CYCLES        (PW),
        .RST_LOW_CYCLES     (RL),
        .RST_SETTLE_CYCLES  (ST),
        .CFG_TIMEOUT_CYCLES (TO),
        .SKIP_FRAMES        (SK)
`ifdef BRINGUP_RETRY_EN
        ,
        .MAX_RETRY          (1)
`endif
    ) dut (
        .xclk       (xclk),
        .reset_n    (reset_n),
        .start      (start),
        .shutdown   (shutdown),
        .sccb_done  (sccb_done),
        .cam_vsync  (cam_vsync),
        .sccb_start (sccb_start),
        .sccb_reset (sccb_reset),
        .cam_pwdn   (cam_pwdn),
        .cam_resetn (cam_resetn),
        .capture_en (capture_en),
        .busy       (busy),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // clock / cycle counter
    always #5 xclk = ~xclk;
    always @(posedge xclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected outputs per state, taken from the state table; S_ERR keeps the camera pins.
    function automatic logic [6:0] model_outs(input logic [3:0] s, input logic [6:0] prev);
        case (s)
            4'd0:    return 7'b0110000;
            4'd1:    return 7'b0110010;
            4'd2:    return 7'b0100010;
            4'd3:    return 7'b0001010;
            4'd4:    return 7'b1001010;
            4'd5:    return 7'b0001010;
            4'd6:    return 7'b0001100;
            4'd7:    return {1'b0, prev[5:3], 3'b001};
            default: return 7'b0100010;
        endcase
    endfunction

    task automatic push_exp(input logic [3:0] s, input int t);
        model_o = model_outs(s, model_o);
        exp_q.push_back({s, model_o, t[31:0]});
    endtask

    // monitor: every state change must match the head of the expected queue
    always @(negedge xclk) begin
        logic [W-1:0] e;
        if (mon_en && state_dbg !== last_state) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", {28'd0, state_dbg}, {28'd0, last_state});
            end else begin
                e = exp_q.pop_front();
                check("state", {28'd0, state_dbg}, {28'd0, e[42:39]});
                check("outs", {25'd0, outs}, {25'd0, e[38:32]});
                check("cycle", cyc, e[31:0]);
            end
        end
        last_state = state_dbg;
    end

    // driver tasks
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge xclk);
    endtask

    task automatic run_to_cfg(output int tcfg);
        int t0;
        @(negedge xclk);
        sccb_done = 1'b0;
        start = 1'b1;
        t0 = cyc + 1;
        push_exp(4'd1, t0);
        push_exp(4'd2, t0 + PW);
        push_exp(4'd3, t0 + PW + RL);
        push_exp(4'd4, t0 + PW + RL + ST);
        tcfg = t0 + PW + RL + ST;
        @(negedge xclk);
        start = 1'b0;
    endtask

    task automatic give_done(output int tskip);
        sccb_done = 1'b1;
        tskip = cyc + 1;
        push_exp(4'd5, tskip);
    endtask

    task automatic vsync_pulse(input bit last);
        @(negedge xclk);
        cam_vsync = 1'b1;
        if (last) push_exp(4'd6, cyc + 3);
        repeat (4) @(negedge xclk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge xclk);
    endtask

    task automatic do_shutdown();
        @(negedge xclk);
        shutdown = 1'b1;
        push_exp(4'd0, cyc + 1);
        repeat (2) @(negedge xclk);
    endtask

    initial begin
        int tcfg;
        int tskip;
        int wait_n;

        // reset state
        #12;
        check("rst_state", {28'd0, state_dbg}, 32'd0);
        check("rst_outs", {25'd0, outs}, {25'd0, RST_OUTS});
        @(negedge xclk);
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge xclk);

        // nominal bring-up
        run_to_cfg(tcfg);
        wait_until(tcfg + 30);
        give_done(tskip);
        repeat (2) @(negedge xclk);
        vsync_pulse(1'b0);
        vsync_pulse(1'b1);
        check("run_capture_en", {31'd0, capture_en}, 32'd1);
        check("run_busy", {31'd0, busy}, 32'd0);
        @(negedge xclk);
        start = 1'b1;
        @(negedge xclk);
        start = 1'b0;
        wait_n = $urandom_range(4, 10);
        repeat (wait_n) @(negedge xclk);
        check("run_ignores_start", {28'd0, state_dbg}, 32'd6);
        do_shutdown();
        shutdown = 1'b0;

        // configuration timeout
        run_to_cfg(tcfg);
`ifdef BRINGUP_RETRY_EN
        push_exp(4'd8, tcfg + TO);
        push_exp(4'd3, tcfg + TO + RL);
        push_exp(4'd4, tcfg + TO + RL + ST);
        wait_until(tcfg + TO + RL + ST + 10);
        give_done(tskip);
        repeat (3) @(negedge xclk);
        do_shutdown();
        shutdown = 1'b0;
        run_to_cfg(tcfg);
        push_exp(4'd8, tcfg + TO);
        push_exp(4'd3, tcfg + TO + RL);
        push_exp(4'd4, tcfg + TO + RL + ST);
        push_exp(4'd7, tcfg + 2 * TO + RL + ST);
        wait_until(tcfg + 2 * TO + RL + ST + 2);
`else
        push_exp(4'd7, tcfg + TO);
        wait_until(tcfg + TO + 2);
`endif
        check("cfg_to_error", {31'd0, error}, 32'd1);
        check("cfg_to_state", {28'd0, state_dbg}, 32'd7);

        // restart from error, then frame timeout with no vsync
        run_to_cfg(tcfg);
        wait_until(tcfg + 5);
        give_done(tskip);
        push_exp(4'd7, tskip + TO);
        wait_until(tskip + TO + 2);
        check("frame_to_capture_en", {31'd0, capture_en}, 32'd0);
        check("frame_to_error", {31'd0, error}, 32'd1);

        // shutdown mid-config, then shutdown together with start in S_OFF
        run_to_cfg(tcfg);
        wait_until(tcfg + 5);
        do_shutdown();
        start = 1'b1;
        @(negedge xclk);
        start = 1'b0;
        repeat (5) @(negedge xclk);
        check("shutdown_beats_start", {28'd0, state_dbg}, 32'd0);
        shutdown = 1'b0;

        // asynchronous reset between edges while in S_SKIP
        run_to_cfg(tcfg);
        wait_until(tcfg + 3);
        give_done(tskip);
        wait_until(tskip + 6);
        @(posedge xclk);
        #2;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", {28'd0, state_dbg}, 32'd0);
        check("async_rst_outs", {25'd0, outs}, {25'd0, RST_OUTS});
        repeat (2) @(negedge xclk);
        reset_n = 1'b1;
        @(negedge xclk);
        model_o = RST_OUTS;
        mon_en = 1'b1;
        repeat (3) @(negedge xclk);

        check("pending_expected", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
